// File: rtl/policy_check.sv
// Access-policy checker: classifies a transaction by domain (ID) and region (byte range), then looks up the read/write permission.
// Latency: one ACLK edge from stable inputs to GRANTED; asynchronous reset forces deny.
// Backpressure: none; the decision is re-evaluated every cycle and the surrounding logic samples it.
//
// Ports:
//   ACLK, ARESETN   clock, asynchronous active-low reset
//   POLICY          [region][domain] permission matrix, entry = {read_permit, write_permit}
//   ID              transaction ID, matched against the domain ID/mask pairs
//   ADDR, LEN, SIZE start address, burst length minus 1, log2 beat size
//   READ_WRITE      0 = read, 1 = write
//   GRANTED         registered decision, 1 = permitted

package pu_pkg;
  typedef struct packed {
    logic read_permit;
    logic write_permit;
  } policy_entry_t;
endpackage

module policy_check #(
  parameter int unsigned NUM_MEM_REGIONS = 2,
  parameter int unsigned NUM_DOMAINS     = 2,
  parameter int unsigned ID_WIDTH        = 16,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0] MEM_REGION_0 = '0,
  parameter logic [ADDR_WIDTH-1:0] MEM_REGION_1 = '0,
  parameter logic [ADDR_WIDTH-1:0] MEM_REGION_2 = '0,
  parameter logic [ADDR_WIDTH-1:0] MEM_REGION_3 = '0,
  parameter int unsigned MEM_REGION_0_LSB = 12,
  parameter int unsigned MEM_REGION_1_LSB = 12,
  parameter int unsigned MEM_REGION_2_LSB = 12,
  parameter int unsigned MEM_REGION_3_LSB = 12,
  parameter logic [ID_WIDTH-1:0] DOMAIN_0_ID   = '0,
  parameter logic [ID_WIDTH-1:0] DOMAIN_1_ID   = '0,
  parameter logic [ID_WIDTH-1:0] DOMAIN_2_ID   = '0,
  parameter logic [ID_WIDTH-1:0] DOMAIN_3_ID   = '0,
  parameter logic [ID_WIDTH-1:0] DOMAIN_0_MASK = '1,
  parameter logic [ID_WIDTH-1:0] DOMAIN_1_MASK = '1,
  parameter logic [ID_WIDTH-1:0] DOMAIN_2_MASK = '1,
  parameter logic [ID_WIDTH-1:0] DOMAIN_3_MASK = '1
) (
  input  logic                                                          ACLK,
  input  logic                                                          ARESETN,
  input  pu_pkg::policy_entry_t [NUM_MEM_REGIONS-1:0][NUM_DOMAINS-1:0]  POLICY,
  input  logic [ID_WIDTH-1:0]                                           ID,
  input  logic [ADDR_WIDTH-1:0]                                         ADDR,
  input  logic [7:0]                                                    LEN,
  input  logic [2:0]                                                    SIZE,
  input  logic                                                          READ_WRITE,
  output logic                                                          GRANTED
);

  localparam logic [3:0][ADDR_WIDTH-1:0] REGION_BASE =
    {MEM_REGION_3, MEM_REGION_2, MEM_REGION_1, MEM_REGION_0};
  localparam int unsigned REGION_LSB [4] =
    '{MEM_REGION_0_LSB, MEM_REGION_1_LSB, MEM_REGION_2_LSB, MEM_REGION_3_LSB};
  localparam logic [3:0][ID_WIDTH-1:0] DOMAIN_REF =
    {DOMAIN_3_ID, DOMAIN_2_ID, DOMAIN_1_ID, DOMAIN_0_ID};
  localparam logic [3:0][ID_WIDTH-1:0] DOMAIN_MASK =
    {DOMAIN_3_MASK, DOMAIN_2_MASK, DOMAIN_1_MASK, DOMAIN_0_MASK};
  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  // Address bits above the region's size; a region of 2^ADDR_WIDTH bytes matches everything.
  function automatic logic [ADDR_WIDTH-1:0] region_mask(input int unsigned lsb);
    if (lsb >= ADDR_WIDTH) return '0;
    return {ADDR_WIDTH{1'b1}} << lsb;
  endfunction

  logic                  dom_hit;
  logic [1:0]            dom_sel;
  logic                  region_hit;
  pu_pkg::policy_entry_t entry;
  logic [ADDR_WIDTH:0]   burst_bytes;
  logic [ADDR_WIDTH:0]   end_addr;
  logic                  wrap;
  logic                  grant_next;

  // Domain select: iterate downward so the lowest matching index wins.
  always_comb begin
    dom_hit = 1'b0;
    dom_sel = '0;
    for (int d = int'(NUM_DOMAINS) - 1; d >= 0; d--) begin
      if ((ID & DOMAIN_MASK[d]) == (DOMAIN_REF[d] & DOMAIN_MASK[d])) begin
        dom_hit = 1'b1;
        dom_sel = 2'(d);
      end
    end
  end

  // Inclusive end address with one extra bit so a wrap past the top of the address space is visible.
  // Assumes ADDR_WIDTH >= 16 so the largest burst (256 beats of 128 B) fits.
  assign burst_bytes = ({{(ADDR_WIDTH-7){1'b0}}, LEN} + ONE) << SIZE;
  assign end_addr    = {1'b0, ADDR} + burst_bytes - ONE;
  assign wrap        = end_addr[ADDR_WIDTH];

  // Region select: iterate upward so the highest-index candidate (the nested one) wins.
  // The entry is picked with constant indices only, which keeps small configurations index-safe.
  always_comb begin
    region_hit = 1'b0;
    entry      = '0;
    for (int r = 0; r < int'(NUM_MEM_REGIONS); r++) begin
      if ((((ADDR ^ REGION_BASE[r]) & region_mask(REGION_LSB[r])) == '0) &&
          (((end_addr[ADDR_WIDTH-1:0] ^ REGION_BASE[r]) & region_mask(REGION_LSB[r])) == '0)) begin
        region_hit = 1'b1;
        entry      = '0;
        for (int d = 0; d < int'(NUM_DOMAINS); d++) begin
          if (dom_sel == 2'(d)) entry = POLICY[r][d];
        end
      end
    end
  end

  assign grant_next = dom_hit && region_hit && !wrap &&
                      (READ_WRITE ? entry.write_permit : entry.read_permit);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) GRANTED <= 1'b0;
    else          GRANTED <= grant_next;
  end

endmodule

// File: tb/tb_policy_check.sv
module tb_policy_check;

  logic                                   ACLK = 1'b0;
  logic                                   ARESETN = 1'b0;
  pu_pkg::policy_entry_t [1:0][1:0]       policy;
  pu_pkg::policy_entry_t [0:0][0:0]       wpolicy;
  logic [15:0]                            id;
  logic [31:0]                            addr;
  logic [7:0]                             len;
  logic [2:0]                             size;
  logic                                   rw;
  logic                                   granted;
  logic                                   wgranted;

  int passed = 0;
  int total  = 0;

  // Test-plan configuration, restated for the reference model.
  longint unsigned reg_base [2] = '{64'h00, 64'h20};
  int unsigned     reg_lsb  [2] = '{6, 5};
  logic [15:0]     dom_id   [2] = '{16'h0800, 16'h0801};
  logic [15:0]     dom_mask [2] = '{16'hFFFF, 16'hFFFF};

  always #5 ACLK = ~ACLK;

  policy_check #(
    .NUM_MEM_REGIONS(2), .NUM_DOMAINS(2), .ID_WIDTH(16), .ADDR_WIDTH(32),
    .MEM_REGION_0(32'h00), .MEM_REGION_0_LSB(6),
    .MEM_REGION_1(32'h20), .MEM_REGION_1_LSB(5),
    .DOMAIN_0_ID(16'h0800), .DOMAIN_0_MASK(16'hFFFF),
    .DOMAIN_1_ID(16'h0801), .DOMAIN_1_MASK(16'hFFFF)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .POLICY(policy), .ID(id), .ADDR(addr),
    .LEN(len), .SIZE(size), .READ_WRITE(rw), .GRANTED(granted)
  );

  // Single region spanning the whole address space, so only the wrap rule can deny.
  policy_check #(
    .NUM_MEM_REGIONS(1), .NUM_DOMAINS(1), .ID_WIDTH(16), .ADDR_WIDTH(32),
    .MEM_REGION_0(32'h0), .MEM_REGION_0_LSB(32),
    .DOMAIN_0_ID(16'h0800), .DOMAIN_0_MASK(16'hFFFF)
  ) wdut (
    .ACLK(ACLK), .ARESETN(ARESETN), .POLICY(wpolicy), .ID(id), .ADDR(addr),
    .LEN(len), .SIZE(size), .READ_WRITE(rw), .GRANTED(wgranted)
  );

  // Reference decision computed with plain integer arithmetic over the byte range.
  function automatic bit model(input logic [15:0] mid, input logic [31:0] maddr,
                               input logic [7:0] mlen, input logic [2:0] msize, input bit mrw,
                               input pu_pkg::policy_entry_t [1:0][1:0] pol);
    int dom = -1;
    int rgn = -1;
    longint unsigned nbytes, last, blk;
    for (int d = 0; d < 2; d++)
      if (dom < 0 && (mid & dom_mask[d]) == (dom_id[d] & dom_mask[d])) dom = d;
    nbytes = (longint'(mlen) + 1) * (64'd1 << msize);
    last   = longint'(maddr) + nbytes - 1;
    if (last > 64'hFFFF_FFFF) return 1'b0;
    for (int r = 0; r < 2; r++) begin
      blk = 64'd1 << reg_lsb[r];
      if (longint'(maddr) / blk == reg_base[r] / blk && last / blk == reg_base[r] / blk) rgn = r;
    end
    if (dom < 0 || rgn < 0) return 1'b0;
    return mrw ? pol[rgn][dom].write_permit : pol[rgn][dom].read_permit;
  endfunction

  // Drive one transaction away from the edge, let one edge pass, settle 1 time unit.
  task automatic apply(input logic [15:0] i, input logic [31:0] a, input logic [7:0] l,
                       input logic [2:0] s, input logic w);
    id = i; addr = a; len = l; size = s; rw = w;
    @(posedge ACLK); #1;
  endtask

  task automatic set_plan_policy();
    policy[0][0] = 2'b10; policy[0][1] = 2'b00;
    policy[1][0] = 2'b01; policy[1][1] = 2'b10;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (granted !== 1'b0) $display("FAIL reset_state: got %b expected 0", granted);
    else passed++;
    @(posedge ACLK); #2;
    ARESETN = 1'b1;
    total++;
    if (granted !== 1'b0) $display("FAIL reset_release_hold: got %b expected 0", granted);
    else passed++;
  endtask

  task automatic test_basic();
    logic [15:0] ids  [5] = '{16'h0800, 16'h0801, 16'h1800, 16'h0800, 16'h0800};
    logic [31:0] adrs [5] = '{32'h00, 32'h00, 32'h00, 32'h40, 32'h00};
    logic        rws  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        exps [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 5; k++) begin
      apply(ids[k], adrs[k], 8'd0, 3'd2, rws[k]);
      total++;
      if (granted !== exps[k]) $display("FAIL basic_%0d: got %b expected %b", k, granted, exps[k]);
      else passed++;
    end
  endtask

  task automatic test_bounds();
    logic [7:0] lens [4] = '{8'h0F, 8'h10, 8'h00, 8'h00};
    logic [2:0] szs  [4] = '{3'd2, 3'd2, 3'd6, 3'd7};
    logic       exps [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      apply(16'h0800, 32'h00, lens[k], szs[k], 1'b0);
      total++;
      if (granted !== exps[k]) $display("FAIL bound_%0d: got %b expected %b", k, granted, exps[k]);
      else passed++;
    end
  endtask

  task automatic test_nested();
    logic [15:0] ids  [3] = '{16'h0800, 16'h0800, 16'h0801};
    logic        rws  [3] = '{1'b1, 1'b0, 1'b0};
    logic        exps [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      apply(ids[k], 32'h20, 8'd0, 3'd2, rws[k]);
      total++;
      if (granted !== exps[k]) $display("FAIL nested_%0d: got %b expected %b", k, granted, exps[k]);
      else passed++;
    end
  endtask

  task automatic test_wrap();
    apply(16'h0800, 32'hFFFF_FFFC, 8'd1, 3'd2, 1'b0);
    total++;
    if (wgranted !== 1'b0) $display("FAIL wrap_deny: got %b expected 0", wgranted);
    else passed++;
    apply(16'h0800, 32'hFFFF_FFFC, 8'd0, 3'd2, 1'b0);
    total++;
    if (wgranted !== 1'b1) $display("FAIL wrap_top_ok: got %b expected 1", wgranted);
    else passed++;
  endtask

  task automatic test_async_reset();
    apply(16'h0800, 32'h00, 8'd0, 3'd2, 1'b0);
    total++;
    if (granted !== 1'b1) $display("FAIL pre_reset: got %b expected 1", granted);
    else passed++;
    #2 ARESETN = 1'b0;
    #1;
    total++;
    if (granted !== 1'b0) $display("FAIL async_reset: got %b expected 0", granted);
    else passed++;
    @(posedge ACLK); #2;
    ARESETN = 1'b1;
    #1;
    total++;
    if (granted !== 1'b0) $display("FAIL post_release_before_edge: got %b expected 0", granted);
    else passed++;
    @(posedge ACLK); #1;
    total++;
    if (granted !== 1'b1) $display("FAIL post_release_edge: got %b expected 1", granted);
    else passed++;
  endtask

  task automatic test_latency();
    apply(16'h1800, 32'h00, 8'd0, 3'd2, 1'b0);
    @(posedge ACLK); #1;
    id = 16'h0800;
    #3;
    total++;
    if (granted !== 1'b0) $display("FAIL latency_before_edge: got %b expected 0", granted);
    else passed++;
    @(posedge ACLK); #1;
    total++;
    if (granted !== 1'b1) $display("FAIL latency_after_edge: got %b expected 1", granted);
    else passed++;
    @(posedge ACLK); #1;
    total++;
    if (granted !== 1'b1) $display("FAIL latency_hold: got %b expected 1", granted);
    else passed++;
  endtask

  task automatic test_random();
    logic [15:0] rid;
    logic [31:0] raddr;
    logic [7:0]  rlen;
    logic [2:0]  rsize;
    logic        rrw;
    bit          exp;
    for (int k = 0; k < 300; k++) begin
      policy = pu_pkg::policy_entry_t'(0);
      for (int r = 0; r < 2; r++)
        for (int d = 0; d < 2; d++) policy[r][d] = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: rid = 16'h0800;
        1: rid = 16'h0801;
        default: rid = 16'($urandom);
      endcase
      raddr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 8'h7F));
      rlen  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8));
      rsize = 3'($urandom_range(0, 7));
      rrw   = 1'($urandom);
      exp   = model(rid, raddr, rlen, rsize, rrw, policy);
      apply(rid, raddr, rlen, rsize, rrw);
      total++;
      if (granted !== exp)
        $display("FAIL random_%0d: id=%h addr=%h len=%h size=%0d rw=%b got %b expected %b",
                 k, rid, raddr, rlen, rsize, rrw, granted, exp);
      else passed++;
    end
  endtask

  initial begin
    wpolicy = 2'b11;
    set_plan_policy();
    id = 16'h0800; addr = '0; len = '0; size = 3'd2; rw = 1'b0;
    test_reset();
    test_basic();
    test_bounds();
    test_nested();
    test_wrap();
    test_async_reset();
    test_latency();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
